// File: rtl/dram_port_arbiter.sv
// Three-port arbiter in front of the single SDRAM controller request port.
// Port 0 (video) has fixed priority but is limited to VIDEO_MAX back-to-back
// grants while port 1 or 2 waits. Ports 1 and 2 share round-robin.
// One transfer at a time: IDLE (arbitrate) -> BUSY (wait mem_ack) -> DONE (ack).
module dram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned VIDEO_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  p0_req,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,

  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic [1:0]            p1_bytesel,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,

  input  logic                  p2_req,
  input  logic                  p2_we,
  input  logic [ADDR_WIDTH-1:0] p2_addr,
  input  logic [DATA_WIDTH-1:0] p2_wdata,
  input  logic [1:0]            p2_bytesel,
  output logic                  p2_ack,
  output logic [DATA_WIDTH-1:0] p2_rdata,

  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [1:0]            mem_bytesel,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,

  output logic [1:0]            grant_id
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Wide enough to hold VIDEO_MAX itself (the saturation value).
  localparam int unsigned VrWidth = $clog2(VIDEO_MAX + 1);
  localparam logic [VrWidth-1:0] VideoMax = VrWidth'(VIDEO_MAX);

  logic [1:0]         state_q;
  logic [VrWidth-1:0] video_run_q;
  logic [1:0]         rr_last_q;

  logic               grant_valid;
  logic [1:0]         grant_sel;
  logic               video_ok;

  // Winner selection for the IDLE state.
  always_comb begin
    grant_valid = 1'b1;
    grant_sel   = 2'd0;
    video_ok    = (video_run_q < VideoMax) || !(p1_req || p2_req);
    if (p0_req && video_ok) begin
      grant_sel = 2'd0;
    end else if (p1_req && p2_req) begin
      grant_sel = (rr_last_q == 2'd1) ? 2'd2 : 2'd1;
    end else if (p1_req) begin
      grant_sel = 2'd1;
    end else if (p2_req) begin
      grant_sel = 2'd2;
    end else begin
      grant_valid = 1'b0;
    end
  end

  // Transfer FSM, fairness state and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      video_run_q <= '0;
      rr_last_q   <= 2'd2;
      grant_id    <= 2'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_bytesel <= 2'b00;
      p0_ack      <= 1'b0;
      p1_ack      <= 1'b0;
      p2_ack      <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
      p2_rdata    <= '0;
    end else begin
      // Acks are single-cycle: only the BUSY->DONE edge raises one.
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p2_ack <= 1'b0;
      case (state_q)
        StIdle: begin
          if (grant_valid) begin
            state_q  <= StBusy;
            mem_req  <= 1'b1;
            grant_id <= grant_sel;
            case (grant_sel)
              2'd1: begin
                mem_we      <= p1_we;
                mem_addr    <= p1_addr;
                mem_wdata   <= p1_wdata;
                mem_bytesel <= p1_bytesel;
              end
              2'd2: begin
                mem_we      <= p2_we;
                mem_addr    <= p2_addr;
                mem_wdata   <= p2_wdata;
                mem_bytesel <= p2_bytesel;
              end
              default: begin
                mem_we      <= 1'b0;
                mem_addr    <= p0_addr;
                mem_wdata   <= '0;
                mem_bytesel <= 2'b11;
              end
            endcase
            if (grant_sel == 2'd0) begin
              if (video_run_q < VideoMax) begin
                video_run_q <= video_run_q + 1'b1;
              end
            end else begin
              video_run_q <= '0;
              rr_last_q   <= grant_sel;
            end
          end
        end
        StBusy: begin
          if (mem_ack) begin
            state_q <= StDone;
            mem_req <= 1'b0;
            case (grant_id)
              2'd1: begin
                p1_rdata <= mem_rdata;
                p1_ack   <= 1'b1;
              end
              2'd2: begin
                p2_rdata <= mem_rdata;
                p2_ack   <= 1'b1;
              end
              default: begin
                p0_rdata <= mem_rdata;
                p0_ack   <= 1'b1;
              end
            endcase
          end
        end
        // Extra cycle lets the master drop req before the next arbitration.
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter; the bench plays the SDRAM controller.
module tb_dram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req;
  logic [23:0] p0_addr;
  logic        p0_ack;
  logic [15:0] p0_rdata;
  logic        p1_req, p1_we;
  logic [23:0] p1_addr;
  logic [15:0] p1_wdata;
  logic [1:0]  p1_bytesel;
  logic        p1_ack;
  logic [15:0] p1_rdata;
  logic        p2_req, p2_we;
  logic [23:0] p2_addr;
  logic [15:0] p2_wdata;
  logic [1:0]  p2_bytesel;
  logic        p2_ack;
  logic [15:0] p2_rdata;
  logic        mem_req, mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_bytesel;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [1:0]  grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  dram_port_arbiter #(
    .ADDR_WIDTH(24),
    .DATA_WIDTH(16),
    .VIDEO_MAX (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .p0_req     (p0_req),
    .p0_addr    (p0_addr),
    .p0_ack     (p0_ack),
    .p0_rdata   (p0_rdata),
    .p1_req     (p1_req),
    .p1_we      (p1_we),
    .p1_addr    (p1_addr),
    .p1_wdata   (p1_wdata),
    .p1_bytesel (p1_bytesel),
    .p1_ack     (p1_ack),
    .p1_rdata   (p1_rdata),
    .p2_req     (p2_req),
    .p2_we      (p2_we),
    .p2_addr    (p2_addr),
    .p2_wdata   (p2_wdata),
    .p2_bytesel (p2_bytesel),
    .p2_ack     (p2_ack),
    .p2_rdata   (p2_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_bytesel(mem_bytesel),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bounded wait for the arbiter to raise mem_req.
  task automatic wait_req();
    int n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("mem_req_seen", {31'd0, mem_req}, 32'd1);
  endtask

  // Controller answers after lat cycles; returns with the DUT in DONE.
  task automatic complete(input int lat, input logic [15:0] rd);
    repeat (lat) tick();
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
  endtask

  logic [1:0] exp_order [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
  logic [1:0] rr_order  [4]  = '{2'd1, 2'd2, 2'd1, 2'd2};

  initial begin
    reset = 1'b1;
    p0_req = 1'b1; p0_addr = 24'h00ABCD;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 24'h0; p1_wdata = 16'h0; p1_bytesel = 2'b11;
    p2_req = 1'b1; p2_we = 1'b0; p2_addr = 24'h0; p2_wdata = 16'h0; p2_bytesel = 2'b11;
    mem_ack = 1'b0; mem_rdata = 16'h0;

    // Reset with every request high: all outputs stay zero.
    repeat (3) tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_acks", {29'd0, p0_ack, p1_ack, p2_ack}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd0);
    check("rst_mem_addr", {8'd0, mem_addr}, 32'd0);
    check("rst_mem_bytesel", {30'd0, mem_bytesel}, 32'd0);

    // First cycle out of reset grants p0; mem_req visible after that edge.
    reset = 1'b0;
    p1_req = 1'b0; p2_req = 1'b0;
    tick();
    check("p0_first_req", {31'd0, mem_req}, 32'd1);
    check("p0_first_gid", {30'd0, grant_id}, 32'd0);
    check("p0_we_bytesel", {29'd0, mem_we, mem_bytesel}, {29'd0, 1'b0, 2'b11});
    check("p0_addr", {8'd0, mem_addr}, 32'h0000ABCD);
    complete(2, 16'hAAAA);
    check("p0_ack", {29'd0, p0_ack, p1_ack, p2_ack}, 32'b100);
    check("p0_rdata", {16'd0, p0_rdata}, 32'h0000AAAA);
    p0_req = 1'b0;
    tick();
    check("p0_ack_one_cycle", {31'd0, p0_ack}, 32'd0);

    // p1 write with 5-cycle controller latency.
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 24'h000100; p1_wdata = 16'hBEEF; p1_bytesel = 2'b01;
    wait_req();
    check("p1_gid", {30'd0, grant_id}, 32'd1);
    check("p1_we_bytesel", {29'd0, mem_we, mem_bytesel}, {29'd0, 1'b1, 2'b01});
    check("p1_addr", {8'd0, mem_addr}, 32'h00000100);
    check("p1_wdata", {16'd0, mem_wdata}, 32'h0000BEEF);
    repeat (5) tick();
    check("p1_busy_hold", {30'd0, mem_req, p1_ack}, 32'b10);
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0;
    check("p1_ack", {29'd0, p0_ack, p1_ack, p2_ack}, 32'b010);
    check("p1_mem_req_drop", {31'd0, mem_req}, 32'd0);
    p1_req = 1'b0;
    tick();
    check("p1_ack_one_cycle", {31'd0, p1_ack}, 32'd0);

    // p2 read returns data only to p2.
    p2_req = 1'b1; p2_we = 1'b0; p2_addr = 24'h002000; p2_bytesel = 2'b11;
    wait_req();
    check("p2_gid", {30'd0, grant_id}, 32'd2);
    check("p2_we", {31'd0, mem_we}, 32'd0);
    complete(1, 16'h1234);
    check("p2_ack", {29'd0, p0_ack, p1_ack, p2_ack}, 32'b001);
    check("p2_rdata", {16'd0, p2_rdata}, 32'h00001234);
    check("p1_rdata_kept", {16'd0, p1_rdata}, 32'h00005555);
    check("p0_rdata_kept", {16'd0, p0_rdata}, 32'h0000AAAA);
    p2_req = 1'b0;
    tick();

    // p1 and p2 both pending: round-robin starting with p1.
    p1_req = 1'b1; p2_req = 1'b1; p1_we = 1'b0; p2_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_req();
      check($sformatf("rr_gid_%0d", i), {30'd0, grant_id}, {30'd0, rr_order[i]});
      complete(1, 16'h0);
    end
    p2_req = 1'b0;

    // p0 and p1 pending: four video grants, then one p1 grant.
    p0_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_req();
      check($sformatf("burst_gid_%0d", i), {30'd0, grant_id}, {30'd0, exp_order[i]});
      complete(0, 16'h0);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (2) tick();

    // Stray mem_ack in IDLE produces nothing.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    check("stray_ack", {28'd0, mem_req, p0_ack, p1_ack, p2_ack}, 32'd0);

    // Reset while BUSY, even with mem_ack arriving, aborts cleanly.
    p2_req = 1'b1;
    wait_req();
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h9999;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0;
    check("rst_busy_req", {31'd0, mem_req}, 32'd0);
    check("rst_busy_acks", {29'd0, p0_ack, p1_ack, p2_ack}, 32'd0);
    check("rst_busy_rdata", {16'd0, p2_rdata}, 32'd0);
    reset = 1'b0;
    wait_req();
    check("rearb_gid", {30'd0, grant_id}, 32'd2);
    complete(3, 16'h7777);
    check("rearb_ack", {29'd0, p0_ack, p1_ack, p2_ack}, 32'b001);
    check("rearb_rdata", {16'd0, p2_rdata}, 32'h00007777);
    p2_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute guard in case the sequence stalls.
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
